// File: rtl/tick_queue_pkg.sv
// Shared sizing and commit-action encoding for the tick-stepped queue.
package tick_queue_pkg;
    localparam int DEPTH_DEF  = 8;
    localparam int WIDTH_DEF  = 4;
    localparam int ADDR_W_DEF = 3;
    localparam int CNT_W_DEF  = ADDR_W_DEF + 1;

    typedef enum logic [1:0] {NONE, PUSH, POP, BOTH} commit_e;

    // Pending push wins on an empty queue; on a non-empty (even full) queue both requests run.
    function automatic commit_e decode_act(input logic push_p, input logic pop_p,
                                           input logic is_full, input logic is_empty);
        commit_e a;
        a = NONE;
        if (push_p && pop_p)
            a = is_empty ? PUSH : BOTH;
        else if (push_p && !is_full)
            a = PUSH;
        else if (pop_p && !is_empty)
            a = POP;
        return a;
    endfunction
endpackage

// File: rtl/tick_queue_req.sv
// Switch request capture: registered rising-edge detect feeding a pending flag cleared by tick.
module tick_queue_req (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic req,
    output logic pending
);
    logic req_q, req_prev, rise;

    assign rise = req_q & ~req_prev;

    // An edge coinciding with a tick re-arms the flag for the next tick instead of being lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_q    <= 1'b0;
            req_prev <= 1'b0;
            pending  <= 1'b0;
        end else begin
            req_q    <= req;
            req_prev <= req_q;
            pending  <= tick ? rise : (pending | rise);
        end
    end
endmodule

// File: rtl/tick_queue.sv
// Circular FIFO committed on divider ticks, with a tick-stepped display scan of the valid entries.
module tick_queue
    import tick_queue_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              Origin_Clock,
    input  logic              reset,
    input  logic              tick,
    input  logic              push_req,
    input  logic              pop_req,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [WIDTH-1:0]  scan_data,
    output logic              scan_valid
);
    localparam int CNT_W = ADDR_W + 1;

    logic [1:0]        reqs, pend;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] head, tail, k;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    commit_e           act;

    assign reqs = {pop_req, push_req};

    // Index 0 captures push, index 1 captures pop.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        tick_queue_req u_req (
            .clk    (Origin_Clock),
            .reset  (reset),
            .tick   (tick),
            .req    (reqs[gi]),
            .pending(pend[gi])
        );
    end

    assign full       = (cnt == CNT_W'(DEPTH));
    assign empty      = (cnt == '0);
    assign count      = cnt;
    assign scan_valid = !empty;
    assign scan_addr  = head + k;
    assign scan_data  = mem[scan_addr];
    assign act        = decode_act(pend[0], pend[1], full, empty);

    always_comb begin
        cnt_nxt = cnt;
        case (act)
            PUSH:    cnt_nxt = cnt + CNT_W'(1);
            POP:     cnt_nxt = cnt - CNT_W'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge Origin_Clock) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            k    <= '0;
            dout <= '0;
        end else if (tick) begin
            if (act == PUSH || act == BOTH)
                tail <= tail + ADDR_W'(1);
            if (act == POP || act == BOTH) begin
                head <= head + ADDR_W'(1);
                dout <= mem[head];
            end
            cnt <= cnt_nxt;
            // Scan index follows the post-commit occupancy so it never points past the tail.
            if (cnt_nxt == '0 || (CNT_W'(k) + CNT_W'(1) >= cnt_nxt))
                k <= '0;
            else
                k <= k + ADDR_W'(1);
        end
    end

    // Storage carries no reset; only slots inside head..tail are ever observed.
    always_ff @(posedge Origin_Clock) begin
        if (reset && tick && (act == PUSH || act == BOTH))
            mem[tail] <= din;
    end
endmodule

// File: tb/tb_tick_queue.sv
// Self-checking bench for tick_queue: vector table plus FIFO scoreboard and scan model.
module tb_tick_queue;
    logic       Origin_Clock = 1'b0;
    logic       reset, tick, push_req, pop_req;
    logic [3:0] din, dout, scan_data;
    logic [3:0] count;
    logic [2:0] scan_addr;
    logic       full, empty, scan_valid;

    tick_queue dut (
        .Origin_Clock(Origin_Clock), .reset(reset), .tick(tick),
        .push_req(push_req), .pop_req(pop_req), .din(din), .dout(dout),
        .full(full), .empty(empty), .count(count), .scan_addr(scan_addr),
        .scan_data(scan_data), .scan_valid(scan_valid)
    );

    always #5 Origin_Clock = ~Origin_Clock;

    typedef struct {
        bit p; bit q; logic [3:0] d;
        int ecnt; logic [3:0] edout; bit efull; bit eempty;
    } vec_t;

    vec_t       vecs[25];
    logic [3:0] sb[$];
    logic [3:0] mdout;
    int         mh, mk;
    int         total = 0, passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    function automatic vec_t mk_vec(bit p, bit q, logic [3:0] d, int c, logic [3:0] o, bit f, bit e);
        vec_t v;
        v.p = p; v.q = q; v.d = d; v.ecnt = c; v.edout = o; v.efull = f; v.eempty = e;
        return v;
    endfunction

    task automatic model_reset();
        sb.delete();
        mdout = 4'd0; mh = 0; mk = 0;
    endtask

    // Scoreboard commit: expected pop value leaves the queue, accepted push data enters it.
    task automatic model_tick(input bit p, input bit q, input logic [3:0] d);
        if (q && sb.size() > 0) begin
            mdout = sb.pop_front();
            mh = (mh + 1) % 8;
        end
        if (p && sb.size() < 8)
            sb.push_back(d);
        if (sb.size() == 0 || mk + 1 >= sb.size())
            mk = 0;
        else
            mk++;
    endtask

    // Called at a negedge with the requests already pending.
    task automatic tick_commit(input bit p, input bit q, input logic [3:0] d);
        din  = d;
        tick = 1'b1;
        @(negedge Origin_Clock);
        tick = 1'b0;
        model_tick(p, q, d);
    endtask

    task automatic req_tick(input bit p, input bit q, input logic [3:0] d);
        push_req = p; pop_req = q; din = d;
        @(negedge Origin_Clock);
        @(negedge Origin_Clock);
        push_req = 1'b0; pop_req = 1'b0;
        tick_commit(p, q, d);
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(sb.size()));
        chk({tag, ".full"}, 32'(full), 32'(sb.size() == 8));
        chk({tag, ".empty"}, 32'(empty), 32'(sb.size() == 0));
        chk({tag, ".dout"}, 32'(dout), 32'(mdout));
        chk({tag, ".scan_valid"}, 32'(scan_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk({tag, ".scan_addr"}, 32'(scan_addr), 32'((mh + mk) % 8));
            chk({tag, ".scan_data"}, 32'(scan_data), 32'(sb[mk]));
        end
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; push_req = 1'b0; pop_req = 1'b0; din = 4'd0;
        model_reset();

        // Reset held three clocks while tick pulses.
        for (int i = 0; i < 3; i++) begin
            @(negedge Origin_Clock);
            tick = 1'b1;
        end
        @(negedge Origin_Clock);
        tick = 1'b0;
        chk("rst.count", 32'(count), 0);
        chk("rst.empty", 32'(empty), 1);
        chk("rst.full", 32'(full), 0);
        chk("rst.dout", 32'(dout), 0);
        chk("rst.scan_valid", 32'(scan_valid), 0);
        reset = 1'b1;
        @(negedge Origin_Clock);

        // Fill, overflow, drain, underflow, then simultaneous push+pop cases.
        for (int i = 0; i < 8; i++)
            vecs[i] = mk_vec(1, 0, 4'(i + 1), i + 1, 4'd0, i == 7, 0);
        vecs[8] = mk_vec(1, 0, 4'd9, 8, 4'd0, 1, 0);
        for (int i = 0; i < 8; i++)
            vecs[9 + i] = mk_vec(0, 1, 4'd0, 7 - i, 4'(i + 1), 0, i == 7);
        vecs[17] = mk_vec(0, 1, 4'd0, 0, 4'd8, 0, 1);
        vecs[18] = mk_vec(1, 0, 4'd5, 1, 4'd8, 0, 0);
        vecs[19] = mk_vec(1, 0, 4'd6, 2, 4'd8, 0, 0);
        vecs[20] = mk_vec(1, 1, 4'd9, 2, 4'd5, 0, 0);
        vecs[21] = mk_vec(0, 1, 4'd0, 1, 4'd6, 0, 0);
        vecs[22] = mk_vec(0, 1, 4'd0, 0, 4'd9, 0, 1);
        vecs[23] = mk_vec(1, 1, 4'd3, 1, 4'd9, 0, 0);
        vecs[24] = mk_vec(0, 1, 4'd0, 0, 4'd3, 0, 1);

        foreach (vecs[i]) begin
            req_tick(vecs[i].p, vecs[i].q, vecs[i].d);
            chk($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].ecnt));
            chk($sformatf("vec%0d.dout", i), 32'(dout), 32'(vecs[i].edout));
            chk($sformatf("vec%0d.full", i), 32'(full), 32'(vecs[i].efull));
            chk($sformatf("vec%0d.empty", i), 32'(empty), 32'(vecs[i].eempty));
            check_state($sformatf("vec%0d", i));
        end

        // Push edge lands in the same cycle as a tick: held over to the next tick.
        push_req = 1'b1; din = 4'd4;
        @(negedge Origin_Clock);
        tick = 1'b1;
        @(negedge Origin_Clock);
        tick = 1'b0;
        model_tick(0, 0, 4'd0);
        chk("collide.hold", 32'(count), 0);
        push_req = 1'b0;
        tick_commit(1, 0, 4'd4);
        chk("collide.commit", 32'(count), 1);
        check_state("collide");

        // Three push edges before one tick collapse into a single push.
        for (int i = 0; i < 5; i++) begin
            push_req = ~push_req;
            @(negedge Origin_Clock);
        end
        @(negedge Origin_Clock);
        push_req = 1'b0;
        tick_commit(1, 0, 4'd7);
        chk("collapse.count", 32'(count), 2);
        tick_commit(0, 0, 4'd0);
        chk("collapse.cleared", 32'(count), 2);
        check_state("collapse");

        // Reset mid-operation drops a pending push.
        push_req = 1'b1; din = 4'd2;
        @(negedge Origin_Clock);
        @(negedge Origin_Clock);
        reset = 1'b0; push_req = 1'b0;
        @(negedge Origin_Clock);
        reset = 1'b1;
        model_reset();
        @(negedge Origin_Clock);
        tick_commit(0, 0, 4'd0);
        chk("rst_mid.count", 32'(count), 0);
        check_state("rst_mid");

        // Tail wraps past slot 7; scan walks the full queue in FIFO order.
        for (int i = 1; i <= 3; i++) req_tick(1, 0, 4'(i));
        for (int i = 0; i < 2; i++) req_tick(0, 1, 4'd0);
        for (int i = 4; i <= 10; i++) req_tick(1, 0, 4'(i));
        chk("wrap.count", 32'(count), 8);
        chk("wrap.full", 32'(full), 1);
        for (int i = 0; i < 8; i++) begin
            tick_commit(0, 0, 4'd0);
            check_state($sformatf("scan%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
